// File: rtl/writeback_stage_if.sv
// writeback_stage_if: execute words in, register-file/memory writes and retire status out
interface writeback_stage_if #(parameter int CNT_W = 16);
    logic             i_vld;
    logic [63:0]      i_reg1;
    logic [31:0]      i_reg2;
    logic             i_of, i_af, i_cf;
    logic             i_mem_ack;
    logic             o_stall;
    logic             o_rf_we;
    logic [2:0]       o_rf_idx;
    logic [31:0]      o_rf_data;
    logic             o_mem_req;
    logic [31:0]      o_mem_addr;
    logic [31:0]      o_mem_data;
    logic [3:0]       o_mem_be;
    logic             o_of, o_af, o_cf;
    logic             o_retire;
    logic [CNT_W-1:0] o_retire_cnt;
    modport master (
        output i_vld, i_reg1, i_reg2, i_of, i_af, i_cf, i_mem_ack,
        input  o_stall, o_rf_we, o_rf_idx, o_rf_data, o_mem_req, o_mem_addr, o_mem_data,
               o_mem_be, o_of, o_af, o_cf, o_retire, o_retire_cnt
    );
    modport slave (
        input  i_vld, i_reg1, i_reg2, i_of, i_af, i_cf, i_mem_ack,
        output o_stall, o_rf_we, o_rf_idx, o_rf_data, o_mem_req, o_mem_addr, o_mem_data,
               o_mem_be, o_of, o_af, o_cf, o_retire, o_retire_cnt
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage: retires execute words to the register file or memory, tracking flags and retire count
module writeback_stage #(
    parameter int CNT_W           = 16,
    parameter bit ALLOW_UNALIGNED = 1'b1
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEM1, MEM2} state_t;
    state_t      state;
    logic [31:0] data;
    logic [1:0]  k;
    logic [1:0]  k_in;
    logic [1:0]  op;
    logic        accept, mem_op, unused_hi;
    assign op          = bus.i_reg2[1:0];
    assign k_in        = ALLOW_UNALIGNED ? bus.i_reg1[1:0] : 2'b00;
    assign accept      = bus.i_vld && state == IDLE;
    assign mem_op      = op != 2'b11 && bus.i_reg2[2];
    assign unused_hi   = ^bus.i_reg2[31:6];
    assign bus.o_stall = state != IDLE;
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            data             <= '0;
            k                <= '0;
            bus.o_rf_we      <= 1'b0;
            bus.o_rf_idx     <= '0;
            bus.o_rf_data    <= '0;
            bus.o_mem_req    <= 1'b0;
            bus.o_mem_addr   <= '0;
            bus.o_mem_data   <= '0;
            bus.o_mem_be     <= '0;
            bus.o_of         <= 1'b0;
            bus.o_af         <= 1'b0;
            bus.o_cf         <= 1'b0;
            bus.o_retire     <= 1'b0;
            bus.o_retire_cnt <= '0;
        end else begin
            bus.o_rf_we  <= 1'b0;
            bus.o_retire <= 1'b0;
            if (accept) begin
                if (op == 2'b00) begin
                    bus.o_of <= bus.i_of;
                    bus.o_af <= bus.i_af;
                    bus.o_cf <= bus.i_cf;
                end
                if (mem_op) begin
                    state          <= MEM1;
                    data           <= bus.i_reg1[63:32];
                    k              <= k_in;
                    bus.o_mem_req  <= 1'b1;
                    bus.o_mem_addr <= {bus.i_reg1[31:2], 2'b00};
                    bus.o_mem_data <= bus.i_reg1[63:32] << {k_in, 3'b000};
                    bus.o_mem_be   <= 4'hf << k_in;
                end else begin
                    bus.o_retire     <= 1'b1;
                    bus.o_retire_cnt <= bus.o_retire_cnt + CNT_W'(1);
                    bus.o_rf_we      <= op != 2'b11;
                    bus.o_rf_idx     <= bus.i_reg2[5:3];
                    bus.o_rf_data    <= bus.i_reg1[63:32];
                end
            end
            // an unaligned word spills its upper bytes into the next aligned word
            if (state != IDLE && bus.i_mem_ack) begin
                if (state == MEM1 && k != 2'b00) begin
                    state          <= MEM2;
                    bus.o_mem_addr <= bus.o_mem_addr + 32'd4;
                    bus.o_mem_data <= data >> (6'd32 - {1'b0, k, 3'b000});
                    bus.o_mem_be   <= 4'hf >> (3'd4 - {1'b0, k});
                end else begin
                    state            <= IDLE;
                    bus.o_mem_req    <= 1'b0;
                    bus.o_retire     <= 1'b1;
                    bus.o_retire_cnt <= bus.o_retire_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage, directly downstream of the execute stage.
- Consumes the execute pipeline words and retires each instruction in one of three ways: register-file write, memory write, or no write for jumps.
- Memory writes use a req/ack handshake; unaligned words are split into two aligned accesses.
- Also holds the architectural OF/AF/CF flags and a retired-instruction counter; stalls upstream while a memory write is outstanding.

Parameters:
- CNT_W, 16, width of retired-instruction counter (wraps).
- ALLOW_UNALIGNED, 1: 1 = split unaligned memory writes; 0 = force addr[1:0] to 0 and do a single access.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_vld  in  1  execute words valid this cycle.
- i_reg1  in  64  [63:32] result data, [31:0] memory address.
- i_reg2  in  32  [1:0] op (00 add, 01 or, 10 mov, 11 jmp), [2] isMemwb (1 = memory destination), [5:3] dest reg index, [31:6] ignored.
- i_of, i_af, i_cf  in  1 each  flags from execute, same cycle as i_reg*.
- i_mem_ack  in  1  memory accepted current request.
- o_stall  out  1  upstream must hold its words.
- o_rf_we  out  1  register-file write enable.
- o_rf_idx  out  3  register-file index.
- o_rf_data  out  32  register-file data.
- o_mem_req  out  1  memory write request.
- o_mem_addr  out  32  word-aligned address.
- o_mem_data  out  32  lane-aligned write data.
- o_mem_be  out  4  byte enables; bit n = byte lane n.
- o_of, o_af, o_cf  out  1 each  architectural flags.
- o_retire  out  1  one-cycle pulse per retired instruction.
- o_retire_cnt  out  CNT_W  retired-instruction count.

Behaviour:
- All outputs are registered.
- Reset, taken at a clk edge with rst=1:
  - State goes to IDLE.
  - All outputs go to 0, including the flags and counter.
  - Reset has priority over every other event.
- States: IDLE, MEM1, MEM2.
- o_stall = (state != IDLE), decoded from the state register.
- Acceptance: the words are accepted only when i_vld=1 and state=IDLE. i_vld during a stall is ignored; upstream holds its words.
- Accepted with op=11 (jmp): no write; o_retire=1 next cycle.
- Accepted with op!=11 and isMemwb=0:
  - Next cycle: o_rf_we=1, o_rf_idx=sr1, o_rf_data=i_reg1[63:32], o_retire=1.
  - Latency is 1 cycle; back-to-back acceptance is allowed.
- Accepted with op!=11 and isMemwb=1:
  - The data, address and k=addr[1:0] are latched and the state goes to MEM1; k is forced to 0 when ALLOW_UNALIGNED=0.
  - MEM1 outputs: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}, o_mem_data=data<<(8k), o_mem_be=4'b1111<<k (4-bit result).
  - In MEM1, i_mem_ack=1 at an edge: if k==0, retire and go to IDLE; otherwise go to MEM2.
- MEM2 outputs: o_mem_req=1, o_mem_addr={addr[31:2],2'b00}+4 (wraps mod 2^32), o_mem_data=data>>(8(4-k)), o_mem_be=4'b1111>>(4-k).
- In MEM2, i_mem_ack=1: retire and go to IDLE.
- Handshake rules:
  - While a request is pending without ack, addr/data/be stay stable.
  - Ack can arrive in the first cycle of req; i_mem_ack while o_mem_req=0 is ignored.
  - o_mem_req drops on the cycle after the final ack.
  - MEM1→MEM2 keeps req high continuously with the new addr/data/be.
- Retire timing: the memory-write o_retire pulse occurs in the cycle after the final ack. No new instruction is accepted in that same edge, because state was not IDLE.
- Flags: on every accepted op=00, o_of/o_af/o_cf <= i_of/i_af/i_cf at the next edge. Other ops leave the flags unchanged.
- o_retire_cnt increments by 1 (mod 2^CNT_W) at the same edge o_retire is set.
- o_rf_we and o_retire are single-cycle pulses unless a new acceptance occurs in the next cycle.
- Reset during MEM1/MEM2:
  - req drops at that edge and the partial write is abandoned.
  - No retire pulse; the counter clears.

Test Plan:
- Reg write: i_vld, reg2={sr1=5, isMemwb=0, op=10}, data 0x12345678 → next cycle o_rf_we=1, idx=5, data=0x12345678, o_retire=1, cnt=1; no o_stall.
- Aligned memory write: addr 0x00001000, data 0xDEADBEEF, ack 2 cycles after req → req held 3 cycles at addr 0x1000, be=1111, data 0xDEADBEEF; o_stall high throughout; o_retire the cycle after ack.
- Unaligned memory write:
  - Stimulus: addr 0x00001002, data 0xAABBCCDD, immediate acks.
  - First access: 0x1000, be=1100, data 0xCCDD0000.
  - Second access: 0x1004, be=0011, data 0x0000AABB.
  - Result: one retire, cnt+1.
  - Repeat with ALLOW_UNALIGNED=0 → single access: 0x1000, be=1111, data 0xAABBCCDD.
- Flags:
  - Accept add with of=1, af=0, cf=1 → o_of=1, o_af=0, o_cf=1.
  - Then or with i_of=0 → flags unchanged.
  - Then jmp → no rf/mem write, retire pulse only.
- Reset mid-op: reset asserted in MEM2 before ack → next edge req=0, state IDLE, stall=0, cnt=0; a fresh reg write afterward completes normally.
- Counter wrap: CNT_W=4, 17 back-to-back reg writes → cnt reads 1; o_rf_we high every cycle, no stall.
